// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined ALU adder/subtractor: op encoding,
// default datapath width and the entry-carry rule.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  function automatic logic entry_carry(input alu_op_e op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit ripple-carry slice made of full_adder cells;
// one slice is evaluated per pipeline stage.
module adder_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice of the carry chain
// per stage, valid/ready on both sides, whole pipe stalls under back-pressure.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic advance;

  // st_* are the values entering stage k: ports for k=0, pipe registers after.
  logic [WIDTH-1:0] st_a      [STAGES];
  logic [WIDTH-1:0] st_b      [STAGES];
  logic [WIDTH-1:0] st_s      [STAGES];
  logic [WIDTH-1:0] st_s_next [STAGES];
  logic             st_c      [STAGES];
  logic             st_v      [STAGES];
  alu_op_e          st_op     [STAGES];
  logic [CHUNK-1:0] slice_sum [STAGES];
  logic             slice_cout[STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign st_op[0] = alu_op_e'(sub);
  assign st_a[0]  = a;
  assign st_b[0]  = (st_op[0] == OP_SUB) ? ~b : b;
  assign st_s[0]  = '0;
  assign st_c[0]  = entry_carry(st_op[0], cin);
  assign st_v[0]  = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_next;

    adder_slice #(.WIDTH(CHUNK)) u_slice (
      .a    (st_a[k][k*CHUNK +: CHUNK]),
      .b    (st_b[k][k*CHUNK +: CHUNK]),
      .cin  (st_c[k]),
      .sum  (slice_sum[k]),
      .cout (slice_cout[k])
    );

    always_comb begin
      s_next = st_s[k];
      s_next[k*CHUNK +: CHUNK] = slice_sum[k];
    end

    assign st_s_next[k] = s_next;

    if (k < LAST) begin : g_pipe
      logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
      logic             c_q, c_d, v_q, v_d;
      alu_op_e          op_q, op_d;

      always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        s_d  = s_q;
        c_d  = c_q;
        v_d  = v_q;
        op_d = op_q;
        if (advance) begin
          a_d  = st_a[k];
          b_d  = st_b[k];
          s_d  = s_next;
          c_d  = slice_cout[k];
          v_d  = st_v[k];
          op_d = st_op[k];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          b_q  <= '0;
          s_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
          op_q <= OP_ADD;
        end else begin
          a_q  <= a_d;
          b_q  <= b_d;
          s_q  <= s_d;
          c_q  <= c_d;
          v_q  <= v_d;
          op_q <= op_d;
        end
      end

      assign st_a[k+1]  = a_q;
      assign st_b[k+1]  = b_q;
      assign st_s[k+1]  = s_q;
      assign st_c[k+1]  = c_q;
      assign st_v[k+1]  = v_q;
      assign st_op[k+1] = op_q;
    end
  end

  // Result registers only reload on a real op, so flags stay put across bubbles.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (advance) begin
      out_valid_d = st_v[LAST];
      if (st_v[LAST]) begin
        sum_d  = st_s_next[LAST];
        cout_d = slice_cout[LAST];
        ovf_d  = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                 (st_s_next[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
        zero_d = (st_s_next[LAST] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
